// File: rtl/pc_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : pc_fetch_unit
// Purpose  : Program-counter stage. Holds the current fetch address and picks
//            the next one from the PC+4 adder, a branch target or a jump target.
//            Also handles stall hold, redirects that arrive during a stall, and
//            a one-cycle trap to an exception vector on a misaligned target.
// Revision : 1.0 - initial release
// ============================================================================
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0080,
  parameter int          COUNT_W    = 16
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic [31:0]        PCAddResult,
  input  logic               Stall,
  input  logic               BranchTaken,
  input  logic [31:0]        BranchTarget,
  input  logic               JumpEn,
  input  logic [31:0]        JumpTarget,
  output logic [31:0]        PCResult,
  output logic               FetchValid,
  output logic               AddrMisaligned,
  output logic [COUNT_W-1:0] FetchCount
);

  // RUN: normal fetch. STALL: PC held, redirects are being collected.
  // TRAP: the single cycle after a misaligned redirect loaded the vector.
  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_TRAP  = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;

  // Redirect captured while stalled, replayed on release.
  logic        pend_valid;
  logic        pend_valid_nxt;
  logic [31:0] pend_target;
  logic [31:0] pend_target_nxt;

  logic [31:0] pc_nxt;
  logic        fv_nxt;
  logic        am_nxt;

  // Same-cycle redirect: a taken branch beats a jump.
  logic        redir_valid;
  logic [31:0] redir_target;

  // Target actually used at release or in RUN, before alignment checking.
  logic        use_target;
  logic [31:0] sel_target;

  localparam logic [COUNT_W-1:0] COUNT_ONE = {{(COUNT_W-1){1'b0}}, 1'b1};

  assign redir_valid  = BranchTaken | JumpEn;
  assign redir_target = BranchTaken ? BranchTarget : JumpTarget;

  // Choose between a fresh redirect and a pending one for the next address.
  always_comb begin
    use_target = 1'b0;
    sel_target = redir_target;
    if (redir_valid) begin
      use_target = 1'b1;
      sel_target = redir_target;
    end else if (pend_valid) begin
      // pend_valid can only be set while in STALL, so in RUN this never fires.
      use_target = 1'b1;
      sel_target = pend_target;
    end
  end

  // Next-state and next-output logic for the fetch FSM.
  always_comb begin
    state_nxt       = state;
    pc_nxt          = PCResult;
    fv_nxt          = 1'b0;
    am_nxt          = 1'b0;
    pend_valid_nxt  = pend_valid;
    pend_target_nxt = pend_target;

    case (state)
      ST_TRAP: begin
        // Fetch the vector instruction; stall and redirects are ignored here.
        pc_nxt    = PCAddResult;
        fv_nxt    = 1'b1;
        state_nxt = ST_RUN;
      end

      ST_RUN, ST_STALL: begin
        if (Stall) begin
          // Hold PC; remember the latest redirect, misaligned or not.
          state_nxt = ST_STALL;
          if (redir_valid) begin
            pend_valid_nxt  = 1'b1;
            pend_target_nxt = redir_target;
          end
        end else begin
          pend_valid_nxt = 1'b0;
          if (use_target && (sel_target[1:0] != 2'b00)) begin
            pc_nxt    = EXC_VECTOR;
            am_nxt    = 1'b1;
            state_nxt = ST_TRAP;
          end else if (use_target) begin
            pc_nxt    = sel_target;
            fv_nxt    = 1'b1;
            state_nxt = ST_RUN;
          end else begin
            pc_nxt    = PCAddResult;
            fv_nxt    = 1'b1;
            state_nxt = ST_RUN;
          end
        end
      end

      default: begin
        // Unused encoding: recover to RUN without touching the PC.
        state_nxt      = ST_RUN;
        pend_valid_nxt = 1'b0;
      end
    endcase
  end

  // FSM state, PC, pending redirect and registered flags.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state          <= ST_RUN;
      PCResult       <= RESET_PC;
      FetchValid     <= 1'b0;
      AddrMisaligned <= 1'b0;
      pend_valid     <= 1'b0;
      pend_target    <= 32'h0000_0000;
    end else begin
      state          <= state_nxt;
      PCResult       <= pc_nxt;
      FetchValid     <= fv_nxt;
      AddrMisaligned <= am_nxt;
      pend_valid     <= pend_valid_nxt;
      pend_target    <= pend_target_nxt;
    end
  end

  // Count accepted fetches; stick at all-ones instead of wrapping.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      FetchCount <= '0;
    end else if (FetchValid && !(&FetchCount)) begin
      FetchCount <= FetchCount + COUNT_ONE;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pc_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc_fetch_unit
// Purpose  : Directed self-checking bench for pc_fetch_unit with an expected-
//            result queue; FetchCount instantiated 4 bits wide to reach
//            saturation quickly.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_pc_fetch_unit;

  logic        Clk;
  logic        Reset;
  logic [31:0] PCAddResult;
  logic        Stall;
  logic        BranchTaken;
  logic [31:0] BranchTarget;
  logic        JumpEn;
  logic [31:0] JumpTarget;
  logic [31:0] PCResult;
  logic        FetchValid;
  logic        AddrMisaligned;
  logic [3:0]  FetchCount;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [31:0] pc;
    logic        fv;
    logic        am;
    logic [3:0]  cnt;
  } exp_t;

  exp_t exp_q[$];

  // Expected-counter model state.
  logic       m_fv;
  logic [3:0] m_cnt;

  pc_fetch_unit #(
    .RESET_PC   (32'h0000_0000),
    .EXC_VECTOR (32'h0000_0080),
    .COUNT_W    (4)
  ) dut (
    .Clk            (Clk),
    .Reset          (Reset),
    .PCAddResult    (PCAddResult),
    .Stall          (Stall),
    .BranchTaken    (BranchTaken),
    .BranchTarget   (BranchTarget),
    .JumpEn         (JumpEn),
    .JumpTarget     (JumpTarget),
    .PCResult       (PCResult),
    .FetchValid     (FetchValid),
    .AddrMisaligned (AddrMisaligned),
    .FetchCount     (FetchCount)
  );

  // The external PC+4 adder.
  assign PCAddResult = PCResult + 32'd4;

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of stimulus, queue the expectation, compare after the edge.
  task automatic step(input logic st, input logic br, input logic [31:0] bt,
                      input logic jp, input logic [31:0] jt,
                      input logic [31:0] epc, input logic efv, input logic eam);
    exp_t e;
    Stall        = st;
    BranchTaken  = br;
    BranchTarget = bt;
    JumpEn       = jp;
    JumpTarget   = jt;
    if (m_fv && (m_cnt != 4'hF)) m_cnt = m_cnt + 4'd1;
    e.pc  = epc;
    e.fv  = efv;
    e.am  = eam;
    e.cnt = m_cnt;
    exp_q.push_back(e);
    m_fv = efv;
    @(posedge Clk);
    #1;
    e = exp_q.pop_front();
    chk("pc",  PCResult,                e.pc);
    chk("fv",  {31'd0, FetchValid},     {31'd0, e.fv});
    chk("am",  {31'd0, AddrMisaligned}, {31'd0, e.am});
    chk("cnt", {28'd0, FetchCount},     {28'd0, e.cnt});
  endtask

  task automatic run(input logic [31:0] epc);
    step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, epc, 1'b1, 1'b0);
  endtask

  initial begin
    Reset = 1'b1; Stall = 1'b0; BranchTaken = 1'b0; BranchTarget = '0;
    JumpEn = 1'b0; JumpTarget = '0;
    m_fv = 1'b0; m_cnt = 4'd0;
    @(posedge Clk); @(posedge Clk); #1;
    chk("rst_pc",  PCResult,                32'h0);
    chk("rst_fv",  {31'd0, FetchValid},     32'h0);
    chk("rst_am",  {31'd0, AddrMisaligned}, 32'h0);
    chk("rst_cnt", {28'd0, FetchCount},     32'h0);
    Reset = 1'b0;

    // Sequential fetch from reset.
    for (int i = 1; i <= 8; i++) run(32'(i * 4));

    // Branch and jump in the same cycle: branch wins.
    step(1'b0, 1'b1, 32'h100, 1'b1, 32'h200, 32'h100, 1'b1, 1'b0);
    run(32'h104);
    step(1'b0, 1'b0, 32'h0, 1'b1, 32'h40, 32'h40, 1'b1, 1'b0);

    // Three stall cycles; the later branch overwrites the earlier jump.
    step(1'b1, 1'b0, 32'h0,   1'b1, 32'h300, 32'h40, 1'b0, 1'b0);
    step(1'b1, 1'b1, 32'h400, 1'b0, 32'h0,   32'h40, 1'b0, 1'b0);
    step(1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   32'h40, 1'b0, 1'b0);
    run(32'h400);
    run(32'h404);

    // Misaligned branch: trap, then redirect during TRAP is ignored.
    step(1'b0, 1'b1, 32'h102, 1'b0, 32'h0,   32'h80, 1'b0, 1'b1);
    step(1'b1, 1'b1, 32'h600, 1'b1, 32'h700, 32'h84, 1'b1, 1'b0);
    run(32'h88);

    // Misaligned target latched during stall traps at release.
    step(1'b1, 1'b0, 32'h0, 1'b1, 32'h203, 32'h88, 1'b0, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0,   32'h80, 1'b0, 1'b1);
    run(32'h84);

    // New redirect at release beats the pending one.
    step(1'b1, 1'b0, 32'h0,   1'b1, 32'h300, 32'h84, 1'b0, 1'b0);
    step(1'b0, 1'b1, 32'h500, 1'b0, 32'h0,   32'h500, 1'b1, 1'b0);

    // Sequential wrap through the top of the address space.
    step(1'b0, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFF8, 32'hFFFF_FFF8, 1'b1, 1'b0);
    run(32'hFFFF_FFFC);
    run(32'h0);

    // Twenty unstalled cycles: counter must sit at 15.
    for (int i = 1; i <= 20; i++) run(32'(i * 4));

    // Asynchronous reset mid-stall with a pending target.
    step(1'b1, 1'b0, 32'h0, 1'b1, 32'h500, 32'h50, 1'b0, 1'b0);
    #2;
    Reset = 1'b1; Stall = 1'b0; JumpEn = 1'b0;
    #1;
    chk("arst_pc",  PCResult,                32'h0);
    chk("arst_fv",  {31'd0, FetchValid},     32'h0);
    chk("arst_am",  {31'd0, AddrMisaligned}, 32'h0);
    chk("arst_cnt", {28'd0, FetchCount},     32'h0);
    @(posedge Clk); #1;
    Reset = 1'b0;
    m_fv = 1'b0; m_cnt = 4'd0;
    run(32'h4);
    step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 32'h4, 1'b0, 1'b0);
    run(32'h8);
    run(32'hC);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
